// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared decode constants and ALU operation encodings
// Contents: register index width, opcode/funct constants, alu_op_e enum,
//           f3_to_alu() mapping of funct3 to the ALU operation.
package core_pkg;

  localparam int REG_AW = 3;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  typedef enum logic [2:0] {
    ALU_NOP = 3'b000,
    ALU_ADD = 3'b001,
    ALU_SUB = 3'b010,
    ALU_AND = 3'b011,
    ALU_OR  = 3'b100,
    ALU_XOR = 3'b101
  } alu_op_e;

  // ALU_NOP marks a funct3 with no base operation (treated as illegal).
  function automatic alu_op_e f3_to_alu(input logic [2:0] f3);
    case (f3)
      F3_ADD:  return ALU_ADD;
      F3_AND:  return ALU_AND;
      F3_OR:   return ALU_OR;
      F3_XOR:  return ALU_XOR;
      default: return ALU_NOP;
    endcase
  endfunction

endpackage

// File: rtl/reg_file_8x15.sv
// rtl/reg_file_8x15.sv - register file, two async read ports, one sync write port
// Ports: clk, rst (sync, active-high, clears all entries), we/waddr/wdata write port,
//        raddr1/rdata1 and raddr2/rdata2 asynchronous read ports. Entry 0 reads as zero.
module reg_file_8x15
  import core_pkg::*;
#(
  parameter int XLEN = 15,
  parameter int NREG = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [XLEN-1:0]   wdata,
  input  logic [REG_AW-1:0] raddr1,
  output logic [XLEN-1:0]   rdata1,
  input  logic [REG_AW-1:0] raddr2,
  output logic [XLEN-1:0]   rdata2
);

  logic [XLEN-1:0] mem [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we && waddr != '0) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == '0) ? '0 : mem[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : mem[raddr2];

endmodule

// File: rtl/id_issue.sv
// rtl/id_issue.sv - decode, scoreboard, writeback forwarding and one-entry issue register
// Ports: clk, rst (sync, active-high); in_valid/in_instr/in_ready instruction handshake;
//        iss_valid/iss_ready/alu_op/op1/op2/iss_rd issue to the ALU;
//        wb_valid/wb_rd/wb_data ALU writeback (low XLEN bits stored); illegal reject pulse.
module id_issue
  import core_pkg::*;
#(
  parameter int XLEN = 15,
  parameter int NREG = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [31:0]       in_instr,
  output logic              in_ready,
  output logic              iss_valid,
  input  logic              iss_ready,
  output logic [2:0]        alu_op,
  output logic [XLEN-1:0]   op1,
  output logic [XLEN-1:0]   op2,
  output logic [REG_AW-1:0] iss_rd,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [31:0]       wb_data,
  output logic              illegal
);

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rd, rs1, rs2;
  logic [XLEN-1:0] imm_sext, wb_val, rf_rdata1, rf_rdata2, op1_val, op2_val;
  logic dec_legal, dec_use_rs2;
  alu_op_e dec_op;
  logic rs1_busy, rs2_busy, hazard, accept;
  logic [NREG-1:0] pending, pending_nxt;
  logic wb_hi_unused;

  assign opcode   = in_instr[6:0];
  assign rd       = in_instr[11:7];
  assign funct3   = in_instr[14:12];
  assign rs1      = in_instr[19:15];
  assign rs2      = in_instr[24:20];
  assign funct7   = in_instr[31:25];
  assign imm_sext = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
  assign wb_val   = wb_data[XLEN-1:0];
  assign wb_hi_unused = ^wb_data[31:XLEN];

  always_comb begin
    dec_legal   = 1'b0;
    dec_use_rs2 = 1'b0;
    dec_op      = ALU_NOP;
    case (opcode)
      OP_R: begin
        dec_use_rs2 = 1'b1;
        if (funct3 == F3_ADD && funct7 == F7_SUB) begin
          dec_legal = 1'b1;
          dec_op    = ALU_SUB;
        end else if (funct7 == F7_BASE && f3_to_alu(funct3) != ALU_NOP) begin
          dec_legal = 1'b1;
          dec_op    = f3_to_alu(funct3);
        end
      end
      OP_I: begin
        if (f3_to_alu(funct3) != ALU_NOP) begin
          dec_legal = 1'b1;
          dec_op    = f3_to_alu(funct3);
        end
      end
      default: ;
    endcase
    // Only x0..x7 exist; an index reaching beyond them rejects the instruction.
    if (rd[4:3] != 2'b00 || rs1[4:3] != 2'b00 || (dec_use_rs2 && rs2[4:3] != 2'b00))
      dec_legal = 1'b0;
  end

  // A same-cycle writeback releases the source, so it does not stall.
  assign rs1_busy = pending[rs1[2:0]] && !(wb_valid && wb_rd == rs1[2:0]);
  assign rs2_busy = dec_use_rs2 && pending[rs2[2:0]] && !(wb_valid && wb_rd == rs2[2:0]);
  assign hazard   = in_valid && dec_legal && (rs1_busy || rs2_busy);
  assign in_ready = !rst && (!iss_valid || iss_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  assign op1_val = (wb_valid && rs1[2:0] != '0 && wb_rd == rs1[2:0]) ? wb_val : rf_rdata1;
  assign op2_val = !dec_use_rs2 ? imm_sext :
                   (wb_valid && rs2[2:0] != '0 && wb_rd == rs2[2:0]) ? wb_val : rf_rdata2;

  // Set after clear: a same-cycle writeback to the new rd leaves it pending.
  always_comb begin
    pending_nxt = pending;
    if (wb_valid) pending_nxt[wb_rd] = 1'b0;
    if (accept && dec_legal) pending_nxt[rd[2:0]] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending   <= '0;
      iss_valid <= 1'b0;
      illegal   <= 1'b0;
      alu_op    <= '0;
      op1       <= '0;
      op2       <= '0;
      iss_rd    <= '0;
    end else begin
      pending <= pending_nxt;
      illegal <= accept && !dec_legal;
      if (accept && dec_legal) begin
        iss_valid <= 1'b1;
        alu_op    <= dec_op;
        op1       <= op1_val;
        op2       <= op2_val;
        iss_rd    <= rd[2:0];
      end else if (iss_ready) begin
        iss_valid <= 1'b0;
      end
    end
  end

  reg_file_8x15 #(.XLEN(XLEN), .NREG(NREG)) u_rf (
    .clk    (clk),
    .rst    (rst),
    .we     (wb_valid),
    .waddr  (wb_rd),
    .wdata  (wb_val),
    .raddr1 (rs1[2:0]),
    .rdata1 (rf_rdata1),
    .raddr2 (rs2[2:0]),
    .rdata2 (rf_rdata2)
  );

endmodule
